fb_read_scheduler: RTL and testbench



---
 rtl/fb_sched_pkg.sv | 28 ++
 rtl/fb_win_addr_gen.sv | 65 ++++++
 rtl/fb_read_scheduler.sv | 161 ++++++++++++++++
 tb/tb_fb_read_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_sched_pkg.sv
// Shared types and constants for the frame-buffer read scheduler.
package fb_sched_pkg;

  localparam int unsigned FB_ADDR_W = 19;
  localparam int unsigned PIXEL_W   = 12;

  // Owner encoding carried in the read tag pipeline
  localparam logic OWN_VGA = 1'b0;
  localparam logic OWN_CNN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic valid;
    logic owner;
  } fb_tag_t;

  // Counter width for a 0..n-1 counter, never below one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_win_addr_gen.sv
// Window address generator: walks a subsampled WIN_W x WIN_H window in raster
// order from a latched base, one step per issue strobe. Offsets are kept as
// running sums so no multiplier is needed.
module fb_win_addr_gen
  import fb_sched_pkg::*;
#(
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned WIN_W     = 28,
  parameter int unsigned WIN_H     = 28,
  parameter int unsigned SUBSAMPLE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [FB_ADDR_W-1:0] base,
  input  logic                 issue,
  output logic [FB_ADDR_W-1:0] addr_c,
  output logic                 last_c
);

  localparam int unsigned COL_W = cnt_w(WIN_W);
  localparam int unsigned ROW_W = cnt_w(WIN_H);
  localparam logic [COL_W-1:0]     COL_MAX  = COL_W'(WIN_W - 1);
  localparam logic [ROW_W-1:0]     ROW_MAX  = ROW_W'(WIN_H - 1);
  localparam logic [FB_ADDR_W-1:0] COL_STEP = FB_ADDR_W'(SUBSAMPLE);
  localparam logic [FB_ADDR_W-1:0] ROW_STEP = FB_ADDR_W'(SUBSAMPLE * SCREEN_W);

  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [FB_ADDR_W-1:0] base_q;
  logic [FB_ADDR_W-1:0] col_off;
  logic [FB_ADDR_W-1:0] row_off;

  // Base latch and raster counters with running offsets
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      col     <= '0;
      row     <= '0;
      col_off <= '0;
      row_off <= '0;
    end else if (load) begin
      base_q  <= base;
      col     <= '0;
      row     <= '0;
      col_off <= '0;
      row_off <= '0;
    end else if (issue) begin
      if (col == COL_MAX) begin
        col     <= '0;
        col_off <= '0;
        row     <= row + 1'b1;
        row_off <= row_off + ROW_STEP;
      end else begin
        col     <= col + 1'b1;
        col_off <= col_off + COL_STEP;
      end
    end
  end

  // Address wraps modulo 2^FB_ADDR_W by construction
  assign addr_c = base_q + row_off + col_off;
  assign last_c = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/fb_read_scheduler.sv
// Frame-buffer read port arbiter: VGA scan-out has strict priority, the CNN
// window fetch fills the free cycles. Returning data is steered by a tag
// pipeline matching the BRAM read latency.
// Optional build macro FB_SCHED_STATS_EN enables the stall-cycle counter.
module fb_read_scheduler
  import fb_sched_pkg::*;
#(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned WIN_W      = 28,
  parameter int unsigned WIN_H      = 28,
  parameter int unsigned SUBSAMPLE  = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                 clk25,
  input  logic                 rst,
  input  logic                 vga_req,
  input  logic [FB_ADDR_W-1:0] vga_addr,
  output logic [PIXEL_W-1:0]   vga_pixel,
  output logic                 vga_pixel_valid,
  input  logic                 cnn_start,
  input  logic [FB_ADDR_W-1:0] cnn_base,
  output logic                 cnn_busy,
  output logic [PIXEL_W-1:0]   cnn_rdata,
  output logic                 cnn_rvalid,
  output logic                 cnn_done,
  output logic [15:0]          cnn_stall_cycles,
  output logic [FB_ADDR_W-1:0] mem_addr,
  input  logic [PIXEL_W-1:0]   mem_rdata
);

  localparam int unsigned LAT = (RD_LATENCY < 1) ? 1 : RD_LATENCY;

  sched_state_e         state;
  fb_tag_t              tag_pipe [LAT];
  fb_tag_t              ret_tag;
  logic                 cnn_issue;
  logic                 start_ok;
  logic                 pipe_has_cnn;
  logic                 vga_ret;
  logic                 cnn_ret;
  logic [FB_ADDR_W-1:0] cnn_addr;
  logic                 cnn_last;
  logic [PIXEL_W-1:0]   vga_hold;
  logic [PIXEL_W-1:0]   cnn_hold;

  assign start_ok  = (state == ST_IDLE) && cnn_start;
  assign cnn_issue = (state == ST_FETCH) && !vga_req;

  fb_win_addr_gen #(
    .SCREEN_W (SCREEN_W),
    .WIN_W    (WIN_W),
    .WIN_H    (WIN_H),
    .SUBSAMPLE(SUBSAMPLE)
  ) u_addr_gen (
    .clk   (clk25),
    .rst   (rst),
    .load  (start_ok),
    .base  (cnn_base),
    .issue (cnn_issue),
    .addr_c(cnn_addr),
    .last_c(cnn_last)
  );

  // VGA always wins the port; CNN address only when FETCH has a free cycle
  assign mem_addr = cnn_issue ? cnn_addr : vga_addr;

  // CNN reads still in flight after this cycle's return (oldest stage excluded)
  always_comb begin
    pipe_has_cnn = 1'b0;
    for (int i = 0; i < int'(LAT) - 1; i++) begin
      if (tag_pipe[i].valid && (tag_pipe[i].owner == OWN_CNN)) pipe_has_cnn = 1'b1;
    end
  end

  // Control FSM with registered busy/done
  always_ff @(posedge clk25) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnn_busy <= 1'b0;
      cnn_done <= 1'b0;
    end else begin
      cnn_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cnn_start) begin
            state    <= ST_FETCH;
            cnn_busy <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (cnn_issue && cnn_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!pipe_has_cnn) begin
            state    <= ST_DONE;
            cnn_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          cnn_busy <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          cnn_busy <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline: one {valid, owner} entry per issued read
  always_ff @(posedge clk25) begin
    if (rst) begin
      for (int i = 0; i < int'(LAT); i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0].valid <= vga_req | cnn_issue;
      tag_pipe[0].owner <= vga_req ? OWN_VGA : OWN_CNN;
      for (int i = 1; i < int'(LAT); i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign ret_tag         = tag_pipe[LAT-1];
  assign vga_ret         = ret_tag.valid && (ret_tag.owner == OWN_VGA);
  assign cnn_ret         = ret_tag.valid && (ret_tag.owner == OWN_CNN);
  assign vga_pixel_valid = vga_ret;
  assign cnn_rvalid      = cnn_ret;

  // Hold registers keep the last value on the output not being fed
  always_ff @(posedge clk25) begin
    if (rst) begin
      vga_hold <= '0;
      cnn_hold <= '0;
    end else begin
      if (vga_ret) vga_hold <= mem_rdata;
      if (cnn_ret) cnn_hold <= mem_rdata;
    end
  end

  assign vga_pixel = vga_ret ? mem_rdata : vga_hold;
  assign cnn_rdata = cnn_ret ? mem_rdata : cnn_hold;

`ifdef FB_SCHED_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of FETCH cycles blocked by VGA
  always_ff @(posedge clk25) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state == ST_FETCH) && vga_req && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign cnn_stall_cycles = stall_q;
`else
  assign cnn_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fb_read_scheduler.sv
// Directed bench for fb_read_scheduler: one instance at RD_LATENCY=1, one at 2.
module tb_fb_read_scheduler;

`ifdef FB_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  logic        rst = 1'b1;
  // instance 0 (RD_LATENCY=1)
  logic        vga_req = 1'b0, cnn_start = 1'b0;
  logic [18:0] vga_addr = '0, cnn_base = '0, mem_addr;
  logic [11:0] vga_pixel, cnn_rdata, mem_rdata;
  logic        vga_pixel_valid, cnn_busy, cnn_rvalid, cnn_done;
  logic [15:0] cnn_stall_cycles;
  // instance 1 (RD_LATENCY=2)
  logic        vga_req2 = 1'b0, cnn_start2 = 1'b0;
  logic [18:0] vga_addr2 = '0, cnn_base2 = '0, mem_addr2;
  logic [11:0] vga_pixel2, cnn_rdata2, mem_rdata2;
  logic        vga_pixel_valid2, cnn_busy2, cnn_rvalid2, cnn_done2;
  logic [15:0] cnn_stall_cycles2;

  fb_read_scheduler #(.RD_LATENCY(1)) dut (
    .clk25(clk25), .rst(rst), .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_pixel(vga_pixel), .vga_pixel_valid(vga_pixel_valid),
    .cnn_start(cnn_start), .cnn_base(cnn_base), .cnn_busy(cnn_busy),
    .cnn_rdata(cnn_rdata), .cnn_rvalid(cnn_rvalid), .cnn_done(cnn_done),
    .cnn_stall_cycles(cnn_stall_cycles), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  fb_read_scheduler #(.RD_LATENCY(2)) dut2 (
    .clk25(clk25), .rst(rst), .vga_req(vga_req2), .vga_addr(vga_addr2),
    .vga_pixel(vga_pixel2), .vga_pixel_valid(vga_pixel_valid2),
    .cnn_start(cnn_start2), .cnn_base(cnn_base2), .cnn_busy(cnn_busy2),
    .cnn_rdata(cnn_rdata2), .cnn_rvalid(cnn_rvalid2), .cnn_done(cnn_done2),
    .cnn_stall_cycles(cnn_stall_cycles2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2)
  );

  // Frame-buffer contents are a fixed function of the address
  function automatic logic [11:0] pix(input logic [18:0] a);
    return a[11:0] ^ {a[18:12], 5'b00000};
  endfunction

  // Expected address of raster sample k in a 28x28 window, step 8, pitch 640
  function automatic logic [18:0] win_addr(input logic [18:0] base, input int k);
    return base + 19'((k / 28) * 5120 + (k % 28) * 8);
  endfunction

  // BRAM models with 1- and 2-cycle read latency
  logic [18:0] ma1_q;
  logic [18:0] ma2_q [2];
  always @(posedge clk25) begin
    ma1_q    <= mem_addr;
    ma2_q[0] <= mem_addr2;
    ma2_q[1] <= ma2_q[0];
  end
  assign mem_rdata  = pix(ma1_q);
  assign mem_rdata2 = pix(ma2_q[1]);

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  // Output monitors and VGA scoreboards
  typedef struct { int due; logic [11:0] d; } vexp_t;
  vexp_t vq0[$];
  vexp_t vq1[$];
  logic [11:0] got [2][8192];
  int ncnn [2]     = '{0, 0};
  int ndone [2]    = '{0, 0};
  int done_cyc [2] = '{0, 0};
  int vseen [2]    = '{0, 0};
  int vbad [2]     = '{0, 0};

  always @(negedge clk25) begin
    vexp_t e;
    if (cnn_rvalid) begin got[0][ncnn[0] % 8192] = cnn_rdata; ncnn[0]++; end
    if (cnn_done) begin ndone[0]++; done_cyc[0] = cyc; end
    if (vga_pixel_valid) begin
      vseen[0]++;
      if (vq0.size() == 0) vbad[0]++;
      else begin
        e = vq0.pop_front();
        if (e.due != cyc || e.d != vga_pixel) vbad[0]++;
      end
    end
    if (vga_req && !rst) begin e.due = cyc + 1; e.d = pix(vga_addr); vq0.push_back(e); end

    if (cnn_rvalid2) begin got[1][ncnn[1] % 8192] = cnn_rdata2; ncnn[1]++; end
    if (cnn_done2) begin ndone[1]++; done_cyc[1] = cyc; end
    if (vga_pixel_valid2) begin
      vseen[1]++;
      if (vq1.size() == 0) vbad[1]++;
      else begin
        e = vq1.pop_front();
        if (e.due != cyc || e.d != vga_pixel2) vbad[1]++;
      end
    end
    if (vga_req2 && !rst) begin e.due = cyc + 2; e.d = pix(vga_addr2); vq1.push_back(e); end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got_v, input int exp_v);
    n_tests++;
    if (got_v != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got_v, got_v, exp_v, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk25);
    #1;
  endtask

  task automatic check_win(input string tag, input int d, input logic [18:0] base, input int first);
    int bad = 0;
    for (int k = 0; k < 784; k++) begin
      if (got[d][(first + k) % 8192] != pix(win_addr(base, k))) bad++;
    end
    check(tag, bad, 0);
  endtask

  int s, b, d0, vs0, vb0, nreq, nsnap, dsnap, pos;

  initial begin
    #(40 * 30000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick;
    rst = 1'b0;
    // ---- reset state
    check("rst_busy", cnn_busy, 0);
    check("rst_done", cnn_done, 0);
    check("rst_rvalid", cnn_rvalid, 0);
    check("rst_vga_valid", vga_pixel_valid, 0);
    check("rst_vga_pixel", vga_pixel, 0);
    check("rst_cnn_rdata", cnn_rdata, 0);
    check("rst_stall", cnn_stall_cycles, 0);
    tick;

    // ---- T1: idle bus, base 0, spurious starts in FETCH and on DONE
    cnn_base = 19'd0; cnn_start = 1'b1;
    s = cyc; b = ncnn[0]; d0 = ndone[0];
    tick;
    cnn_start = 1'b0;
    check("t1_busy_rise", cnn_busy, 1);
    check("t1_addr_s0", mem_addr, 0);
    tick;
    check("t1_addr_s1", mem_addr, 8);
    while (cyc < s + 786) begin
      cnn_start = (cyc == s + 50);
      cnn_base  = (cyc == s + 50) ? 19'h01234 : 19'd0;
      tick;
    end
    cnn_start = 1'b0;
    check("t1_done_pulse", cnn_done, 1);
    cnn_start = 1'b1; cnn_base = 19'd5;
    tick;
    cnn_start = 1'b0;
    check("t1_busy_fall", cnn_busy, 0);
    check("t1_done_single_cycle", cnn_done, 0);
    repeat (30) tick;
    check("t1_busy_after_ignored_start", cnn_busy, 0);
    check("t1_samples", ncnn[0] - b, 784);
    check("t1_done_count", ndone[0] - d0, 1);
    check("t1_done_latency", done_cyc[0] - s, 786);
    check("t1_sample0", got[0][b % 8192], pix(19'd0));
    check("t1_sample1", got[0][(b + 1) % 8192], pix(19'd8));
    check("t1_sample28", got[0][(b + 28) % 8192], pix(19'd5120));
    check_win("t1_window", 0, 19'd0, b);
    check("t1_stall", cnn_stall_cycles, 0);

    // ---- T2: VGA requests alternate 1/0 through FETCH
    cnn_base = 19'd0; cnn_start = 1'b1; vga_req = 1'b0;
    s = cyc; b = ncnn[0]; d0 = ndone[0]; vs0 = vseen[0]; vb0 = vbad[0]; nreq = 0;
    tick;
    cnn_start = 1'b0;
    while (ndone[0] == d0 && cyc < s + 2500) begin
      vga_req  = ((cyc - s) % 2) == 1;
      vga_addr = 19'($urandom);
      if (vga_req) nreq++;
      tick;
    end
    vga_req = 1'b0;
    repeat (4) tick;
    check("t2_done_count", ndone[0] - d0, 1);
    check("t2_done_latency", done_cyc[0] - s, 1570);
    check("t2_samples", ncnn[0] - b, 784);
    check_win("t2_window", 0, 19'd0, b);
    check("t2_vga_returns", vseen[0] - vs0, nreq);
    check("t2_vga_bad", vbad[0] - vb0, 0);
    check("t2_stall", cnn_stall_cycles, STATS ? 784 : 0);

    // ---- T3: line timing, VGA active 640 of 800, CNN only in blanking
    cnn_base = 19'h00123; cnn_start = 1'b1;
    vga_req = 1'b1; vga_addr = 19'($urandom);
    s = cyc; b = ncnn[0]; d0 = ndone[0]; vs0 = vseen[0]; vb0 = vbad[0]; nreq = 1;
    tick;
    cnn_start = 1'b0;
    while (ndone[0] == d0 && cyc < s + 8000) begin
      pos      = (cyc - s + 100) % 800;
      vga_req  = pos < 640;
      vga_addr = 19'($urandom);
      if (vga_req) nreq++;
      tick;
    end
    vga_req = 1'b0;
    repeat (4) tick;
    check("t3_done_count", ndone[0] - d0, 1);
    check("t3_samples", ncnn[0] - b, 784);
    check_win("t3_window", 0, 19'h00123, b);
    check("t3_vga_returns", vseen[0] - vs0, nreq);
    check("t3_vga_bad", vbad[0] - vb0, 0);
    check("t3_stall", cnn_stall_cycles, STATS ? 3099 : 0);

    // ---- T4: reset at the 100th sample, then a fresh full fetch
    cnn_base = 19'h00200; cnn_start = 1'b1;
    s = cyc; b = ncnn[0]; d0 = ndone[0];
    tick;
    cnn_start = 1'b0;
    while ((ncnn[0] - b) < 100 && cyc < s + 400) tick;
    check("t4_reached_100", ncnn[0] - b, 100);
    rst = 1'b1;
    tick;
    check("t4_rst_busy", cnn_busy, 0);
    check("t4_rst_done", cnn_done, 0);
    check("t4_rst_rvalid", cnn_rvalid, 0);
    check("t4_rst_vga_valid", vga_pixel_valid, 0);
    check("t4_rst_vga_pixel", vga_pixel, 0);
    check("t4_rst_cnn_rdata", cnn_rdata, 0);
    check("t4_rst_stall", cnn_stall_cycles, 0);
    rst = 1'b0;
    nsnap = ncnn[0]; dsnap = ndone[0];
    repeat (20) tick;
    check("t4_no_rvalid_after_rst", ncnn[0] - nsnap, 0);
    check("t4_no_done_after_rst", ndone[0] - dsnap, 0);
    cnn_base = 19'd0; cnn_start = 1'b1;
    s = cyc; b = ncnn[0]; d0 = ndone[0];
    tick;
    cnn_start = 1'b0;
    while (ndone[0] == d0 && cyc < s + 1200) tick;
    repeat (4) tick;
    check("t4_refetch_done", ndone[0] - d0, 1);
    check("t4_refetch_samples", ncnn[0] - b, 784);
    check_win("t4_refetch_window", 0, 19'd0, b);

    // ---- T5: RD_LATENCY=2, base near top of address space
    cnn_base2 = 19'h7FFF0; cnn_start2 = 1'b1;
    s = cyc; b = ncnn[1]; d0 = ndone[1]; vs0 = vseen[1]; vb0 = vbad[1]; nreq = 0;
    tick;
    cnn_start2 = 1'b0;
    check("t5_addr_s0", mem_addr2, 32'h7FFF0);
    tick;
    check("t5_addr_s1", mem_addr2, 32'h7FFF8);
    tick;
    check("t5_addr_wrap", mem_addr2, 0);
    while (ndone[1] == d0 && cyc < s + 2500) begin
      vga_req2  = ((cyc - s) % 2) == 1;
      vga_addr2 = 19'($urandom);
      if (vga_req2) nreq++;
      tick;
    end
    vga_req2 = 1'b0;
    repeat (4) tick;
    check("t5_done_count", ndone[1] - d0, 1);
    check("t5_samples", ncnn[1] - b, 784);
    check("t5_sample2", got[1][(b + 2) % 8192], pix(19'd0));
    check_win("t5_window", 1, 19'h7FFF0, b);
    check("t5_vga_returns", vseen[1] - vs0, nreq);
    check("t5_vga_bad", vbad[1] - vb0, 0);
    check("t5_busy_end", cnn_busy2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
